ddr_phase_tuner: RTL and testbench
==================================

# ddr_phase_tuner

- Automatic read-capture phase calibrator for the DDR clocking path.
- Sweeps the PLL dynamic phase control across all 2^PHASE_BITS steps and scores each step from a data-checker pass/fail stream.
- Finds the widest contiguous passing window and parks the phase at its centre, driving the matching 50% duty code.
- Sits between the DDR read data checker and the read-clock PLL's psda/dutyda inputs.

## Interface
Parameters:
- PHASE_BITS, 4, width of phase/duty control codes (2^PHASE_BITS steps)
- SETTLE_CYCLES, 64, clocks waited after each phase change before sampling
- SAMPLE_CYCLES, 256, clocks of checker observation per step
- ERR_LIMIT, 0, maximum errors per step still scored as pass

Ports:
- clk  in  1  system clock; sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- pll_locked  in  1  lock status of the tuned PLL
- sample_valid  in  1  checker result strobe
- sample_ok  in  1  checker result; 0 = error when sample_valid=1
- psda  out  PHASE_BITS  registered phase code to PLL
- dutyda  out  PHASE_BITS  psda + 2^(PHASE_BITS-1), modulo 2^PHASE_BITS
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- fail  out  1  last sweep found no passing step; held until next start
- win_start  out  PHASE_BITS  start phase of chosen window
- win_len  out  PHASE_BITS+1  length of chosen window (0..2^PHASE_BITS)

## Operation
FSM states:
- **IDLE**
  - start=1: latch current psda as saved_psda; phase=0; clear cur/best/first run trackers; go to WAIT_LOCK.
- **WAIT_LOCK**
  - Drive psda=phase.
  - When pll_locked=1: load settle counter; go to SETTLE.
- **SETTLE**
  - Count SETTLE_CYCLES, then clear the error counter and go to SAMPLE.
- **SAMPLE**
  - Count SAMPLE_CYCLES clocks.
  - Each clock with sample_valid=1 and sample_ok=0 increments the error counter, which saturates at ERR_LIMIT+1.
  - At the end, pass = (errors <= ERR_LIMIT); go to NEXT.
- pll_locked=0 in SETTLE or SAMPLE → WAIT_LOCK; the current step restarts, earlier results are kept.
- **NEXT**
  - pass: cur_len++; if cur_len was 0, cur_start=phase.
  - fail: cur_len=0.
  - If the new cur_len is strictly greater than best_len, copy the current run to best, so the earliest window wins ties.
  - The first run touching phase 0 is also recorded as first_len.
  - phase = max: go to CENTER. Otherwise phase++ and go to SETTLE (not WAIT_LOCK).
- **CENTER**
  - Apply wrap merge if compiled in (see Configuration).
  - best_len=0: fail=1, psda=saved_psda.
  - Otherwise: fail=0, psda = (best_start + (best_len-1)>>1) mod 2^PHASE_BITS.
  - Load win_start/win_len; go to DONE.
- **DONE**
  - done=1 for one cycle; go to IDLE.

Rules:
- busy=1 in every state except IDLE.
- start while busy is ignored.
- All steps passing gives win_start=0, win_len=2^PHASE_BITS, psda=2^(PHASE_BITS-1)-1.
- dutyda is always derived combinationally from registered psda.

## Timing
- Reset values: psda=0, dutyda=2^(PHASE_BITS-1), busy=0, done=0, fail=0, win_start=0, win_len=0; FSM in IDLE.
- start is sampled at an edge in IDLE; busy=1 from the next edge.
- psda changes on the edge that enters SETTLE or WAIT_LOCK, at least SETTLE_CYCLES before sampling begins.
- Per step with lock held: SETTLE_CYCLES + SAMPLE_CYCLES + 1 clocks.
- Full sweep: 2^PHASE_BITS × (SETTLE_CYCLES + SAMPLE_CYCLES + 1) + 4 clocks.
- Final psda, win_*, and fail are valid on the same edge that asserts done.
- Reset mid-sweep aborts immediately to reset values; no partial result is applied.

## Configuration
- **DDR_PHASE_WRAP_EN** defined:
  - Applies in CENTER when phase 0 passed and the final run is still open (cur_len>0 at the last step, not the full circle).
  - The leading and trailing runs merge into one window: start=cur_start, len=cur_len+first_len.
  - The merged window replaces best if its length is strictly greater.
- **DDR_PHASE_WRAP_EN** undefined:
  - Windows are linear; no merge logic is synthesised.

## Test plan
- Lock held, all steps pass, PHASE_BITS=4 → win_start=0, win_len=16, psda=7, dutyda=15, fail=0, one done pulse.
- Pass only at phases 5..9 → win_start=5, win_len=5, psda=7, dutyda=15.
- All steps fail, psda=3 before start → fail=1, win_len=0, psda=3 after done.
- Pass at 0,1,14,15:
  - with DDR_PHASE_WRAP_EN → win_start=14, win_len=4, psda=15.
  - without it → win_start=0, win_len=2, psda=0.
- Drop pll_locked for 10 clocks mid-SAMPLE at phase 6 → step 6 re-runs in full after relock; result is identical to the undisturbed run; sweep lengthens accordingly.
- Assert rst mid-sweep at phase 9 → all outputs return to reset values asynchronously; next start performs a complete fresh sweep.

Source files
------------

// File: rtl/ddr_phase_tuner.sv
// Read-capture phase calibrator: sweeps PLL phase, scores each step, parks at the widest window's centre.
// Optional DDR_PHASE_WRAP_EN merges a window that wraps from the last phase back to phase 0.
module ddr_phase_tuner #(
  parameter int PHASE_BITS    = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int SAMPLE_CYCLES = 256,
  parameter int ERR_LIMIT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pll_locked,
  input  logic                  sample_valid,
  input  logic                  sample_ok,
  output logic [PHASE_BITS-1:0] psda,
  output logic [PHASE_BITS-1:0] dutyda,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [PHASE_BITS-1:0] win_start,
  output logic [PHASE_BITS:0]   win_len
);

  localparam int STEPS   = 1 << PHASE_BITS;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int EW      = $clog2(ERR_LIMIT + 2);
  localparam int LW      = PHASE_BITS + 1;

  localparam logic [CW-1:0]         SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]         SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [EW-1:0]         ERR_MAX     = EW'(ERR_LIMIT);
  localparam logic [EW-1:0]         ERR_SAT     = EW'(ERR_LIMIT + 1);
  localparam logic [PHASE_BITS-1:0] PHASE_LAST  = {PHASE_BITS{1'b1}};
  localparam logic [PHASE_BITS-1:0] HALF_TURN   = PHASE_BITS'(STEPS / 2);

  typedef enum logic [2:0] {IDLE, WAIT_LOCK, SETTLE, SAMPLE, NEXT, CENTER, DONE} state_t;

  state_t                state;
  logic [PHASE_BITS-1:0] phase;
  logic [PHASE_BITS-1:0] saved_psda;
  logic [CW-1:0]         cnt;
  logic [EW-1:0]         err;
  logic                  step_pass;
  logic [PHASE_BITS-1:0] cur_start;
  logic [LW-1:0]         cur_len;
  logic [PHASE_BITS-1:0] best_start;
  logic [LW-1:0]         best_len;
  logic [LW-1:0]         first_len;

  logic [EW-1:0]         err_next;
  logic [LW-1:0]         new_len;
  logic [PHASE_BITS-1:0] new_start;
  logic [PHASE_BITS-1:0] fin_start;
  logic [LW-1:0]         fin_len;
  logic [LW-1:0]         half_len;
  logic [PHASE_BITS-1:0] center_code;

  assign dutyda = psda + HALF_TURN;

  always_comb begin
    err_next  = err;
    if (sample_valid && !sample_ok && (err != ERR_SAT))
      err_next = err + 1'b1;
    new_len   = step_pass ? (cur_len + 1'b1) : '0;
    new_start = (cur_len == '0) ? phase : cur_start;
    fin_start = best_start;
    fin_len   = best_len;
`ifdef DDR_PHASE_WRAP_EN
    // A run still open at the last phase continues into the run that began at phase 0.
    if ((first_len != '0) && (cur_len != '0) && (cur_len != LW'(STEPS)) &&
        ((cur_len + first_len) > best_len)) begin
      fin_start = cur_start;
      fin_len   = cur_len + first_len;
    end
`endif
    half_len    = (fin_len - 1'b1) >> 1;
    center_code = fin_start + half_len[PHASE_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      saved_psda <= '0;
      cnt        <= '0;
      err        <= '0;
      step_pass  <= 1'b0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      first_len  <= '0;
      psda       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      win_start  <= '0;
      win_len    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            saved_psda <= psda;
            phase      <= '0;
            psda       <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            first_len  <= '0;
            fail       <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          psda <= phase;
          if (pll_locked) begin
            cnt   <= SETTLE_LOAD;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!pll_locked) begin
            state <= WAIT_LOCK;
          end else if (cnt == '0) begin
            cnt   <= SAMPLE_LOAD;
            err   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          // Losing lock discards this step's partial score; the step restarts from WAIT_LOCK.
          if (!pll_locked) begin
            state <= WAIT_LOCK;
          end else begin
            err <= err_next;
            if (cnt == '0) begin
              step_pass <= (err_next <= ERR_MAX);
              state     <= NEXT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        NEXT: begin
          cur_len <= new_len;
          if (step_pass)
            cur_start <= new_start;
          if (new_len > best_len) begin
            best_start <= new_start;
            best_len   <= new_len;
          end
          if (step_pass && (new_start == '0))
            first_len <= new_len;
          if (phase == PHASE_LAST) begin
            state <= CENTER;
          end else begin
            phase <= phase + 1'b1;
            psda  <= phase + 1'b1;
            cnt   <= SETTLE_LOAD;
            state <= SETTLE;
          end
        end
        CENTER: begin
          if (fin_len == '0) begin
            fail <= 1'b1;
            psda <= saved_psda;
          end else begin
            fail <= 1'b0;
            psda <= center_code;
          end
          win_start <= fin_start;
          win_len   <= fin_len;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_phase_tuner.sv
// Randomized scoreboard bench for ddr_phase_tuner; reference model picks windows from a pass map.
// Expectations follow DDR_PHASE_WRAP_EN when the macro is defined for the build.
module tb_ddr_phase_tuner;

  localparam int PB      = 4;
  localparam int S       = 4;
  localparam int P       = 8;
  localparam int EL      = 1;
  localparam int STEPS   = 1 << PB;
  localparam int L       = S + P + 1;
  localparam int SWEEP_T = STEPS * L + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pll_locked;
  logic          sample_valid;
  logic          sample_ok;
  logic [PB-1:0] psda;
  logic [PB-1:0] dutyda;
  logic          busy;
  logic          done;
  logic          fail;
  logic [PB-1:0] win_start;
  logic [PB:0]   win_len;

  typedef struct {
    logic          fl;
    logic [PB-1:0] ws;
    logic [PB:0]   wl;
    logic [PB-1:0] ps;
  } exp_t;

  exp_t    sb[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      errs[STEPS];
  bit      pass_map[STEPS];
  int      model_psda = 0;

  ddr_phase_tuner #(
    .PHASE_BITS(PB), .SETTLE_CYCLES(S), .SAMPLE_CYCLES(P), .ERR_LIMIT(EL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pll_locked(pll_locked),
    .sample_valid(sample_valid), .sample_ok(sample_ok), .psda(psda), .dutyda(dutyda),
    .busy(busy), .done(done), .fail(fail), .win_start(win_start), .win_len(win_len)
  );

  always #5 clk = ~clk;

  task automatic check_output(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Each passing phase gets 0..EL errors, each failing phase EL+1..P errors.
  task automatic set_pattern(input logic [STEPS-1:0] mask);
    for (int k = 0; k < STEPS; k++) begin
      pass_map[k] = mask[k];
      errs[k] = mask[k] ? int'($urandom_range(EL, 0)) : int'($urandom_range(P, EL + 1));
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    int best_s = 0;
    int best_l = 0;
    for (int s = 0; s < STEPS; s++) begin
      int l = 0;
      while ((s + l < STEPS) && pass_map[s + l]) l++;
      if (l > best_l) begin
        best_s = s;
        best_l = l;
      end
    end
`ifdef DDR_PHASE_WRAP_EN
    begin
      int lead = 0;
      while ((lead < STEPS) && pass_map[lead]) lead++;
      if ((lead > 0) && (lead < STEPS) && pass_map[STEPS-1]) begin
        int trail = 0;
        while (pass_map[STEPS-1-trail]) trail++;
        if (lead + trail > best_l) begin
          best_s = STEPS - trail;
          best_l = lead + trail;
        end
      end
    end
`endif
    e.fl = (best_l == 0);
    e.ws = PB'(best_s);
    e.wl = (PB+1)'(best_l);
    e.ps = (best_l == 0) ? PB'(model_psda) : PB'((best_s + (best_l - 1) / 2) % STEPS);
    return e;
  endfunction

  task automatic check_reset_values(string tag);
    check_output({tag, "_psda"}, int'(psda), 0);
    check_output({tag, "_dutyda"}, int'(dutyda), STEPS / 2);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_done"}, int'(done), 0);
    check_output({tag, "_fail"}, int'(fail), 0);
    check_output({tag, "_win_start"}, int'(win_start), 0);
    check_output({tag, "_win_len"}, int'(win_len), 0);
  endtask

  // Timed mode places errors by the spec's step schedule (window offsets S..S+P-1 after each settle entry)
  // and drives random noise elsewhere; untimed mode answers from the phase currently presented.
  task automatic drive_inputs(input int t, input bit timed);
    if (timed) begin
      if ((t >= 1) && ((t - 1) / L < STEPS) && ((t - 1) % L >= S) && ((t - 1) % L < S + P)) begin
        if (((t - 1) % L) - S < errs[(t - 1) / L]) begin
          sample_valid = 1'b1;
          sample_ok    = 1'b0;
        end else begin
          sample_valid = 1'($urandom);
          sample_ok    = 1'b1;
        end
      end else begin
        sample_valid = 1'($urandom);
        sample_ok    = 1'($urandom);
      end
    end else if (pass_map[int'(psda)]) begin
      sample_valid = 1'($urandom);
      sample_ok    = 1'b1;
    end else begin
      sample_valid = 1'b1;
      sample_ok    = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input bit timed, input bit drop_lock, input int abort_t, input int extra_start_t);
    exp_t e;
    int   t = 0;
    int   seen6 = -1;
    bit   got = 1'b0;
    e = model();
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while ((t < 3 * SWEEP_T) && !got) begin
      drive_inputs(t, timed);
      if (drop_lock && (seen6 < 0) && (psda == PB'(6))) seen6 = t;
      pll_locked = !(drop_lock && (seen6 >= 0) && (t >= seen6 + S + 3) && (t < seen6 + S + 13));
      start = (t == extra_start_t);
      if (t == abort_t) begin
        #3 rst = 1'b1;
        #1 check_reset_values("abort");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        void'(sb.pop_back());
        model_psda = 0;
        return;
      end
      @(posedge clk);
      #1 t++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    pll_locked = 1'b1;
    if (!got) begin
      check_output("sweep_timeout", 0, 1);
      void'(sb.pop_back());
    end else if (drop_lock) begin
      check_output("lock_drop_lengthens", int'(t > SWEEP_T), 1);
    end else begin
      check_output("sweep_cycles", t, SWEEP_T);
    end
    model_psda = int'(e.ps);
  endtask

  // Monitor: every done pulse is matched against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("fail_flag", int'(fail), int'(e.fl));
          check_output("win_start", int'(win_start), int'(e.ws));
          check_output("win_len", int'(win_len), int'(e.wl));
          check_output("psda_final", int'(psda), int'(e.ps));
          check_output("dutyda_final", int'(dutyda), (int'(e.ps) + STEPS / 2) % STEPS);
          check_output("busy_at_done", int'(busy), 1);
        end
        @(negedge clk);
        check_output("done_one_cycle", int'(done), 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pll_locked = 1'b1;
    sample_valid = 1'b0;
    sample_ok = 1'b1;
    #12 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    set_pattern(16'hFFFF);
    apply_stimulus(1'b1, 1'b0, -1, -1);
    set_pattern(16'h03E0);
    apply_stimulus(1'b1, 1'b0, -1, -1);
    set_pattern(16'h001C);
    apply_stimulus(1'b1, 1'b0, -1, -1);
    set_pattern(16'h0000);
    apply_stimulus(1'b1, 1'b0, -1, -1);
    set_pattern(16'hC003);
    apply_stimulus(1'b1, 1'b0, -1, -1);
    set_pattern(16'h03E0);
    apply_stimulus(1'b0, 1'b1, -1, -1);
    set_pattern(16'($urandom));
    apply_stimulus(1'b1, 1'b0, 1 + 9 * L + S + 2, -1);
    for (int r = 0; r < 3; r++) begin
      set_pattern(16'($urandom));
      apply_stimulus(1'b1, 1'b0, -1, (r == 1) ? 40 : -1);
    end

    repeat (5) @(posedge clk);
    check_output("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
